// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed seven-segment scan driver for NUM_DIGITS hex digits.
// Per-digit enable, decimal points, PWM brightness and a one-cycle
// ghost blank at each digit change. All display inputs are
// double-buffered and take effect only at a frame boundary.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-high reset
//   digits      hex value per digit, digit i = [4i+3:4i]
//   dp_in       decimal point per digit
//   digit_en    1 = digit displayed, 0 = blanked
//   brightness  duty setting, 0 = dimmest, all-ones = full
//   load        capture display inputs into the pending buffer
//   anode       one-hot digit select (polarity per parameter)
//   LED         segments {g,f,e,d,c,b,a} (polarity per parameter)
//   dp          decimal point segment
//   frame_tick  pulse when slot 0 of a new frame reaches the outputs

module seven_segment_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int PRESCALE         = 1024,
  parameter int BRIGHT_BITS      = 4,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              LED,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CW = (PRESCALE > 1)
                    ? $clog2(PRESCALE) : 1;
  localparam int SW = (NUM_DIGITS > 1)
                    ? $clog2(NUM_DIGITS) : 1;
  // wide enough for (2**BRIGHT_BITS) * PRESCALE
  localparam int OW = BRIGHT_BITS + CW + 1;
  localparam int DW = 4 * NUM_DIGITS;

  // "off" patterns; XOR with an active-high value
  // applies the output polarity
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                            : {NUM_DIGITS{1'b0}};
  localparam logic [6:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF =
    (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // scan counters
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          cnt_wrap;
  logic          slot_last;
  logic          boundary;

  // pending buffer
  logic [DW-1:0]          pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]  pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]  pend_en_q, pend_en_d;
  logic [BRIGHT_BITS-1:0] pend_bright_q, pend_bright_d;
  logic                   pend_valid_q, pend_valid_d;

  // active buffer
  logic [DW-1:0]          act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]  act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]  act_en_q, act_en_d;
  logic [BRIGHT_BITS-1:0] act_bright_q, act_bright_d;

  // boundary seen last cycle -> tick next cycle
  logic bnd_q, bnd_d;

  // registered outputs
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            led_q, led_d;
  logic                  dp_q, dp_d;
  logic                  tick_q, tick_d;

  // current-slot view
  logic [3:0]            cur_hex;
  logic                  cur_dp;
  logic                  cur_en;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            seg;
  logic [OW-1:0]         on_full;
  logic [OW-1:0]         on_cyc;
  logic                  lit;

  // counters
  always_comb begin
    cnt_wrap  = (cnt_q == CW'(PRESCALE - 1));
    slot_last = (slot_q == SW'(NUM_DIGITS - 1));
    boundary  = cnt_wrap && slot_last;
    cnt_d     = cnt_q + 1'b1;
    slot_d    = slot_q;
    if (cnt_wrap) begin
      cnt_d = '0;
      if (slot_last) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
    bnd_d = boundary;
  end

  // double buffering; a load on the boundary
  // bypasses pending and goes live at once
  always_comb begin
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_en_d     = pend_en_q;
    pend_bright_d = pend_bright_q;
    pend_valid_d  = pend_valid_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_en_d      = act_en_q;
    act_bright_d  = act_bright_q;
    if (load) begin
      pend_digits_d = digits;
      pend_dp_d     = dp_in;
      pend_en_d     = digit_en;
      pend_bright_d = brightness;
      pend_valid_d  = 1'b1;
    end
    if (boundary) begin
      if (load) begin
        act_digits_d = digits;
        act_dp_d     = dp_in;
        act_en_d     = digit_en;
        act_bright_d = brightness;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        act_digits_d = pend_digits_q;
        act_dp_d     = pend_dp_q;
        act_en_d     = pend_en_q;
        act_bright_d = pend_bright_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  // select the digit for the current slot
  always_comb begin
    cur_hex = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    onehot  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SW'(i)) begin
        cur_hex   = act_digits_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_en    = act_en_q[i];
        onehot[i] = 1'b1;
      end
    end
  end

  // hex to active-high gfedcba
  always_comb begin
    seg = 7'h00;
    unique case (cur_hex)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
    endcase
  end

  // PWM window: cnt 1..on_cyc, cnt 0 is the ghost blank
  always_comb begin
    on_full = ((OW'(act_bright_q) + OW'(1))
              * OW'(PRESCALE)) >> BRIGHT_BITS;
    on_cyc  = (on_full == '0) ? OW'(1) : on_full;
    lit     = cur_en
           && (cnt_q != '0)
           && (OW'(cnt_q) <= on_cyc);
  end

  always_comb begin
    anode_d = AN_OFF;
    led_d   = SEG_OFF;
    dp_d    = DP_OFF;
    tick_d  = bnd_q;
    if (lit) begin
      anode_d = onehot ^ AN_OFF;
      led_d   = seg ^ SEG_OFF;
      dp_d    = cur_dp ^ DP_OFF;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      slot_q        <= '0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_en_q     <= '0;
      pend_bright_q <= '0;
      pend_valid_q  <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_en_q      <= '0;
      act_bright_q  <= '0;
      bnd_q         <= 1'b0;
      anode_q       <= AN_OFF;
      led_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_en_q     <= pend_en_d;
      pend_bright_q <= pend_bright_d;
      pend_valid_q  <= pend_valid_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_en_q      <= act_en_d;
      act_bright_q  <= act_bright_d;
      bnd_q         <= bnd_d;
      anode_q       <= anode_d;
      led_q         <= led_d;
      dp_q          <= dp_d;
      tick_q        <= tick_d;
    end
  end

  assign anode      = anode_q;
  assign LED        = led_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: 4 digits, PRESCALE 16,
// 4-bit brightness, active-low anodes and segments.

module tb_seven_segment_scan_driver;

  logic        clock;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic        load;
  logic [3:0]  anode;
  logic [6:0]  LED;
  logic        dp;
  logic        frame_tick;

  int cyc;
  int npass;
  int ntot;

  typedef struct {
    logic [3:0] val;
    logic [6:0] led;
  } hex_vec_t;

  hex_vec_t tbl [16];

  seven_segment_scan_driver #(
    .NUM_DIGITS      (4),
    .PRESCALE        (16),
    .BRIGHT_BITS     (4),
    .ANODE_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW  (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .digits    (digits),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .brightness(brightness),
    .load      (load),
    .anode     (anode),
    .LED       (LED),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    ntot++;
    if (got === exp) begin
      npass++;
    end else begin
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               name, cyc, got, exp);
    end
  endtask

  // after step(), outputs show counter state index cyc-1
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    load  = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  // captured on the next edge, i.e. at counter state index cyc
  task automatic load_vals(input logic [15:0] d,
                           input logic [3:0]  p,
                           input logic [3:0]  e,
                           input logic [3:0]  b);
    digits     = d;
    dp_in      = p;
    digit_en   = e;
    brightness = b;
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  task automatic blank_run(input string tag);
    for (int n = 0; n < 70; n++) begin
      step();
      chk({tag, "_an"}, 16'(anode), 16'hF);
      chk({tag, "_led"}, 16'(LED), 16'h7F);
      chk({tag, "_ft"}, 16'(frame_tick),
          (cyc == 65) ? 16'd1 : 16'd0);
    end
  endtask

  initial begin
    int c;
    int f;
    cyc        = 0;
    npass      = 0;
    ntot       = 0;
    reset      = 1'b1;
    load       = 1'b0;
    digits     = '0;
    dp_in      = '0;
    digit_en   = '0;
    brightness = '0;

    tbl[0]  = '{4'h0, 7'h40};
    tbl[1]  = '{4'h1, 7'h79};
    tbl[2]  = '{4'h2, 7'h24};
    tbl[3]  = '{4'h3, 7'h30};
    tbl[4]  = '{4'h4, 7'h19};
    tbl[5]  = '{4'h5, 7'h12};
    tbl[6]  = '{4'h6, 7'h02};
    tbl[7]  = '{4'h7, 7'h78};
    tbl[8]  = '{4'h8, 7'h00};
    tbl[9]  = '{4'h9, 7'h10};
    tbl[10] = '{4'hA, 7'h08};
    tbl[11] = '{4'hB, 7'h03};
    tbl[12] = '{4'hC, 7'h46};
    tbl[13] = '{4'hD, 7'h21};
    tbl[14] = '{4'hE, 7'h06};
    tbl[15] = '{4'hF, 7'h0E};

    // reset state
    @(posedge clock);
    #1;
    chk("rst_an", 16'(anode), 16'hF);
    chk("rst_led", 16'(LED), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_ft", 16'(frame_tick), 16'h0);

    // blank after reset, tick at output cycle 65
    do_reset();
    blank_run("blank");

    // load before first boundary
    do_reset();
    load_vals(16'h3210, 4'b0001, 4'hF, 4'hF);
    run_to(64);
    chk("ld_pre_an", 16'(anode), 16'hF);
    chk("ld_pre_ft", 16'(frame_tick), 16'h0);
    run_to(65);
    chk("ld_ft", 16'(frame_tick), 16'h1);
    chk("ld_c0_an", 16'(anode), 16'hF);
    run_to(66);
    chk("ld_s0_an", 16'(anode), 16'hE);
    chk("ld_s0_led", 16'(LED), 16'h40);
    chk("ld_s0_dp", 16'(dp), 16'h0);
    chk("ld_s0_ft", 16'(frame_tick), 16'h0);
    run_to(80);
    chk("ld_c15_an", 16'(anode), 16'hE);
    run_to(81);
    chk("ld_s1c0_an", 16'(anode), 16'hF);
    run_to(82);
    chk("ld_s1_an", 16'(anode), 16'hD);
    chk("ld_s1_led", 16'(LED), 16'h79);
    chk("ld_s1_dp", 16'(dp), 16'h1);

    // brightness 0: lit only at cnt 1
    load_vals(16'h3210, 4'b0001, 4'hF, 4'h0);
    run_to(130);
    chk("b0_c1_an", 16'(anode), 16'hE);
    run_to(131);
    chk("b0_c2_an", 16'(anode), 16'hF);
    run_to(162);
    chk("b0_s2_an", 16'(anode), 16'hB);
    chk("b0_s2_led", 16'(LED), 16'h24);
    run_to(163);
    chk("b0_s2c2_an", 16'(anode), 16'hF);

    // brightness 7: lit at cnt 1..8
    run_to(170);
    load_vals(16'h3210, 4'b0001, 4'hF, 4'h7);
    for (int k = 0; k < 16; k++) begin
      run_to(193 + k);
      chk("b7_an", 16'(anode),
          (k >= 1 && k <= 8) ? 16'hE : 16'hF);
    end

    // mid-frame load during slot 1 of frame 4
    run_to(275);
    load_vals(16'hFEDC, 4'b0001, 4'hF, 4'hF);
    run_to(278);
    chk("mid_s1_an", 16'(anode), 16'hD);
    chk("mid_s1_led", 16'(LED), 16'h79);
    run_to(310);
    chk("mid_s3_an", 16'(anode), 16'h7);
    chk("mid_s3_led", 16'(LED), 16'h30);
    run_to(315);
    chk("mid_s3_dim", 16'(anode), 16'hF);
    run_to(321);
    chk("mid_ft", 16'(frame_tick), 16'h1);
    run_to(322);
    chk("new_s0_an", 16'(anode), 16'hE);
    chk("new_s0_led", 16'(LED), 16'h46);
    run_to(370);
    chk("new_s3_an", 16'(anode), 16'h7);
    chk("new_s3_led", 16'(LED), 16'h0E);
    run_to(379);
    chk("new_s3_full", 16'(anode), 16'h7);

    // load on the boundary cycle goes live at once
    run_to(383);
    load_vals(16'h89AB, 4'b0000, 4'hF, 4'hF);
    run_to(385);
    chk("bnd_ft", 16'(frame_tick), 16'h1);
    run_to(386);
    chk("bnd_s0_an", 16'(anode), 16'hE);
    chk("bnd_s0_led", 16'(LED), 16'h03);
    chk("bnd_s0_dp", 16'(dp), 16'h1);
    run_to(434);
    chk("bnd_s3_an", 16'(anode), 16'h7);
    chk("bnd_s3_led", 16'(LED), 16'h00);

    // per-digit enable 0101
    run_to(440);
    load_vals(16'h3210, 4'b0000, 4'b0101, 4'hF);
    run_to(450);
    chk("en_s0_an", 16'(anode), 16'hE);
    chk("en_s0_led", 16'(LED), 16'h40);
    for (int k = 0; k < 16; k++) begin
      run_to(465 + k);
      chk("en_s1_an", 16'(anode), 16'hF);
      chk("en_s1_led", 16'(LED), 16'h7F);
    end
    run_to(482);
    chk("en_s2_an", 16'(anode), 16'hB);
    chk("en_s2_led", 16'(LED), 16'h24);
    for (int k = 0; k < 16; k++) begin
      run_to(497 + k);
      chk("en_s3_an", 16'(anode), 16'hF);
      chk("en_s3_led", 16'(LED), 16'h7F);
    end

    // full hex set on digit 0, dp follows bit 0
    for (int i = 0; i < 16; i++) begin
      c = cyc;
      f = c / 64;
      load_vals({12'h000, tbl[i].val},
                {3'b000, tbl[i].val[0]},
                4'hF, 4'hF);
      run_to(64 * (f + 1) + 2);
      chk("hex_an", 16'(anode), 16'hE);
      chk("hex_led", 16'(LED), 16'(tbl[i].led));
      chk("hex_dp", 16'(dp),
          tbl[i].val[0] ? 16'h0 : 16'h1);
    end

    // pending load, then async reset at slot 2 cnt 7
    c = cyc;
    f = c / 64;
    run_to(64 * f + 20);
    load_vals(16'h3210, 4'b1111, 4'hF, 4'hF);
    run_to(64 * f + 39);
    chk("ar_pre_an", 16'(anode), 16'hB);
    chk("ar_pre_led", 16'(LED), 16'h40);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_an", 16'(anode), 16'hF);
    chk("ar_led", 16'(LED), 16'h7F);
    chk("ar_dp", 16'(dp), 16'h1);
    chk("ar_ft", 16'(frame_tick), 16'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
    blank_run("post");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
